ext_ram_arbiter: RTL and testbench
==================================

Name: ext_ram_arbiter

Overview:
Sequences every access to the 32-byte external SRAM on the TinyTapeout pins and shares that SRAM between two requesters.
- Port 0 is the Neander-X CPU memory port.
- Port 1 is a program loader/debug port.
The block generates the SRAM cycles: address setup, output-enable window, write-enable pulse with data setup/hold, and data-bus direction. It arbitrates round-robin, so neither requester starves. It sits between the CPU core and the uo_out/uio pin mapping.

Parameters:
- ADDR_W, 5: SRAM address width.
- DATA_W, 8: data width.
- RD_WAIT, 2: cycles ram_oe is held before read data is sampled; legal range 1..15.
- WE_W, 1: ram_we pulse width in cycles; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request; level, held until cpu_ack.
- cpu_we  in  1  1=write, 0=read; stable while cpu_req.
- cpu_addr  in  ADDR_W  CPU address; stable while cpu_req.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data; valid while cpu_ack.
- ldr_req, ldr_we, ldr_addr, ldr_wdata  in  1/1/ADDR_W/DATA_W  loader port; same rules as the CPU port.
- ldr_ack  out  1  loader completion pulse.
- ldr_rdata  out  DATA_W  loader read data.
- ram_addr  out  ADDR_W  SRAM address pins.
- ram_oe  out  1  SRAM output enable, active high.
- ram_we  out  1  SRAM write enable, active high.
- ram_dq_out  out  DATA_W  write data to the pins.
- ram_dq_oe  out  1  pad direction: 1 = drive the bus.
- ram_dq_in  in  DATA_W  data from the pins.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs are 0: ram_addr, ram_dq_out, cpu_rdata, ldr_rdata, both acks, ram_oe, ram_we, ram_dq_oe, busy.
  - The round-robin pointer is set to "last=LDR", so the CPU wins the first tie.
- Reset mid-cycle: strobes drop immediately and the in-flight access is abandoned with no ack. Requesters must re-issue.
- States: IDLE, RD, WR_SU, WR_WE, WR_HD, ACK.
- Arbitration in IDLE, at a clock edge where any req=1:
  - With a single requester, it is granted.
  - With both requesting, the requester not granted last wins.
  - The winner's addr/we/wdata are latched into internal registers. ram_addr and ram_dq_out drive from those registers only; request inputs never drive the pins directly.
- Read transaction:
  - RD lasts RD_WAIT cycles with ram_oe=1.
  - At the edge that leaves RD, ram_dq_in is captured into the winner's rdata register.
  - ACK follows for one cycle with the winner's ack=1.
- Write transaction:
  - WR_SU: 1 cycle, ram_dq_oe=1.
  - WR_WE: WE_W cycles, ram_dq_oe=1 and ram_we=1.
  - WR_HD: 1 cycle, ram_dq_oe=1 and ram_we=0.
  - ACK follows for one cycle.
- Latency, from the request-sampling edge to the ack cycle: read = RD_WAIT+1 cycles; write = WE_W+3 cycles.
- ACK always returns to IDLE. A req still high during ACK is ignored; it is arbitrated at the next edge in IDLE, so back-to-back accesses have a one-cycle IDLE gap.
- Invariants:
  - ram_oe and ram_dq_oe are never both 1.
  - ram_we=1 only when ram_dq_oe=1.
  - ram_addr and ram_dq_out are constant for the whole transaction and hold their last value in IDLE.
  - A non-granted requester's rdata is unchanged.
- Wait counter is 4-bit and loaded with RD_WAIT-1 or WE_W-1. A parameter outside 1..15 is an elaboration error.

Decomposition:
- Package neander_ram_pkg holds:
  - the state enum (IDLE, RD, WR_SU, WR_WE, WR_HD, ACK);
  - the requester id enum (REQ_CPU=0, REQ_LDR=1);
  - the WAIT_CNT_W=4 constant.
- One sub-module: ram_rr_arb2, a combinational 2-way round-robin grant plus a registered last-grant pointer that updates only on an accept.

Test Plan:
- Reset with ram_dq_in=8'hA5 and no requests: all outputs 0 and busy=0.
- CPU read addr 5'h1F, ram_dq_in=8'h3C, RD_WAIT=2: ram_oe high 2 cycles; cpu_ack and cpu_rdata=8'h3C in cycle 3; ldr_rdata stays 0.
- Loader write addr 5'h04, data 8'h7E, WE_W=1:
  - ram_dq_oe high 3 cycles;
  - ram_we high only in the middle cycle;
  - ram_addr=5'h04 throughout;
  - ldr_ack in cycle 4.
- CPU and loader both request reads continuously from reset: grants alternate CPU, LDR, CPU, LDR, with an IDLE cycle between transactions; each ack lands on the correct port.
- rst_n pulled low during WR_WE: ram_we and ram_dq_oe drop asynchronously; no ack is issued; after release the arbiter is in IDLE and a fresh request completes normally.
- Bus-contention check over random traffic, asserted every cycle: ram_oe & ram_dq_oe is never 1, and ram_we never rises without ram_dq_oe.

Source files
------------

// File: rtl/neander_ram_pkg.sv
// Shared types and constants for the external SRAM arbiter.
package neander_ram_pkg;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        WR_SU = 3'd2,
        WR_WE = 3'd3,
        WR_HD = 3'd4,
        ACK   = 3'd5
    } state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_LDR = 1'b1
    } req_id_t;

endpackage

// File: rtl/ram_rr_arb2.sv
// Two-way round-robin grant; the last-grant pointer moves only when a grant is accepted.
module ram_rr_arb2
    import neander_ram_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_req_cpu,
    input  logic    i_req_ldr,
    input  logic    i_accept,
    output logic    o_gnt_vld,
    output req_id_t o_gnt_id
);

    req_id_t r_last;

    // Grant the sole requester, or on a tie the one that was not served last.
    always_comb begin
        o_gnt_vld = i_req_cpu | i_req_ldr;
        o_gnt_id  = REQ_CPU;
        if (i_req_cpu && i_req_ldr) begin
            o_gnt_id = (r_last == REQ_LDR) ? REQ_CPU : REQ_LDR;
        end else if (i_req_ldr) begin
            o_gnt_id = REQ_LDR;
        end
    end

    // Remember who was served; reset favours the CPU on the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= REQ_LDR;
        end else if (i_accept && o_gnt_vld) begin
            r_last <= o_gnt_id;
        end
    end

endmodule

// File: rtl/ext_ram_arbiter.sv
// Sequences external SRAM read/write cycles and shares the SRAM between
// the CPU port and the loader/debug port.
module ext_ram_arbiter
    import neander_ram_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8,
    parameter int RD_WAIT = 2,
    parameter int WE_W    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_oe,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_dq_out,
    output logic              ram_dq_oe,
    input  logic [DATA_W-1:0] ram_dq_in,
    output logic              busy
);

    localparam int CNT_MAX = (2 ** WAIT_CNT_W) - 1;

    if (RD_WAIT < 1 || RD_WAIT > CNT_MAX) begin : g_bad_rd_wait
        $error("RD_WAIT must be within 1..15");
    end
    if (WE_W < 1 || WE_W > CNT_MAX) begin : g_bad_we_w
        $error("WE_W must be within 1..15");
    end

    localparam logic [WAIT_CNT_W-1:0] RD_LOAD = WAIT_CNT_W'(RD_WAIT - 1);
    localparam logic [WAIT_CNT_W-1:0] WE_LOAD = WAIT_CNT_W'(WE_W - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WAIT_CNT_W-1:0] r_wait;
    logic [WAIT_CNT_W-1:0] w_wait_nxt;
    req_id_t               r_owner;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W-1:0]     r_cpu_rdata;
    logic [DATA_W-1:0]     r_ldr_rdata;

    logic                  w_gnt_vld;
    req_id_t               w_gnt_id;
    logic                  w_accept;
    logic                  w_sel_we;
    logic [ADDR_W-1:0]     w_sel_addr;
    logic [DATA_W-1:0]     w_sel_wdata;
    logic                  w_rd_done;

    ram_rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req_cpu (cpu_req),
        .i_req_ldr (ldr_req),
        .i_accept  (w_accept),
        .o_gnt_vld (w_gnt_vld),
        .o_gnt_id  (w_gnt_id)
    );

    assign w_accept    = (r_state == IDLE) && w_gnt_vld;
    assign w_rd_done   = (r_state == RD) && (r_wait == '0);
    assign w_sel_we    = (w_gnt_id == REQ_LDR) ? ldr_we    : cpu_we;
    assign w_sel_addr  = (w_gnt_id == REQ_LDR) ? ldr_addr  : cpu_addr;
    assign w_sel_wdata = (w_gnt_id == REQ_LDR) ? ldr_wdata : cpu_wdata;

    assign ram_addr   = r_addr;
    assign ram_dq_out = r_wdata;
    assign cpu_rdata  = r_cpu_rdata;
    assign ldr_rdata  = r_ldr_rdata;

    // State and wait-counter registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    // Next-state sequencing and strobes decoded from the current state.
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        ram_oe      = 1'b0;
        ram_we      = 1'b0;
        ram_dq_oe   = 1'b0;
        cpu_ack     = 1'b0;
        ldr_ack     = 1'b0;
        busy        = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (w_gnt_vld) begin
                    if (w_sel_we) begin
                        w_state_nxt = WR_SU;
                    end else begin
                        w_state_nxt = RD;
                        w_wait_nxt  = RD_LOAD;
                    end
                end
            end
            RD: begin
                ram_oe = 1'b1;
                if (r_wait == '0) begin
                    w_state_nxt = ACK;
                end else begin
                    w_wait_nxt = r_wait - WAIT_CNT_W'(1);
                end
            end
            WR_SU: begin
                ram_dq_oe   = 1'b1;
                w_state_nxt = WR_WE;
                w_wait_nxt  = WE_LOAD;
            end
            WR_WE: begin
                ram_dq_oe = 1'b1;
                ram_we    = 1'b1;
                if (r_wait == '0) begin
                    w_state_nxt = WR_HD;
                end else begin
                    w_wait_nxt = r_wait - WAIT_CNT_W'(1);
                end
            end
            WR_HD: begin
                ram_dq_oe   = 1'b1;
                w_state_nxt = ACK;
            end
            ACK: begin
                cpu_ack     = (r_owner == REQ_CPU);
                ldr_ack     = (r_owner == REQ_LDR);
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Latch the winner's request at accept and capture read data when RD ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner     <= REQ_CPU;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_ldr_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_owner <= w_gnt_id;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
            end
            if (w_rd_done) begin
                if (r_owner == REQ_CPU) begin
                    r_cpu_rdata <= ram_dq_in;
                end else begin
                    r_ldr_rdata <= ram_dq_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_ext_ram_arbiter.sv
// Self-checking bench for ext_ram_arbiter: directed cases plus random traffic
// against a transaction-level reference model.
module tb_ext_ram_arbiter;

    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 8;
    localparam int RD_WAIT = 2;
    localparam int WE_W    = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              ldr_req = 1'b0, ldr_we = 1'b0;
    logic [ADDR_W-1:0] ldr_addr = '0;
    logic [DATA_W-1:0] ldr_wdata = '0;
    logic              ldr_ack;
    logic [DATA_W-1:0] ldr_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_oe, ram_we, ram_dq_oe, busy;
    logic [DATA_W-1:0] ram_dq_out;
    logic [DATA_W-1:0] ram_dq_in = 8'hA5;

    ext_ram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_WAIT(RD_WAIT), .WE_W(WE_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .ram_addr(ram_addr), .ram_oe(ram_oe), .ram_we(ram_we),
        .ram_dq_out(ram_dq_out), .ram_dq_oe(ram_dq_oe), .ram_dq_in(ram_dq_in),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state (port 0 = CPU, port 1 = loader)
    int                m_last;
    logic [DATA_W-1:0] m_rdata [2];
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_dout;
    int                last_winner;

    // Pending request payloads per port
    logic              p_we    [2];
    logic [ADDR_W-1:0] p_addr  [2];
    logic [DATA_W-1:0] p_wdata [2];
    bit                pend    [2];
    bit                use_fix = 1'b0;
    logic [DATA_W-1:0] fix_val = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last     = 1;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
        m_addr     = '0;
        m_dout     = '0;
    endtask

    task automatic drive(input bit r0, input bit r1);
        cpu_req   = r0;
        cpu_we    = p_we[0];
        cpu_addr  = p_addr[0];
        cpu_wdata = p_wdata[0];
        ldr_req   = r1;
        ldr_we    = p_we[1];
        ldr_addr  = p_addr[1];
        ldr_wdata = p_wdata[1];
    endtask

    task automatic check_idle();
        chk("idle_busy",   32'(busy),      0);
        chk("idle_oe",     32'(ram_oe),    0);
        chk("idle_we",     32'(ram_we),    0);
        chk("idle_dqoe",   32'(ram_dq_oe), 0);
        chk("idle_cack",   32'(cpu_ack),   0);
        chk("idle_lack",   32'(ldr_ack),   0);
        chk("idle_addr",   32'(ram_addr),  32'(m_addr));
        chk("idle_dout",   32'(ram_dq_out), 32'(m_dout));
        chk("idle_crdata", 32'(cpu_rdata), 32'(m_rdata[0]));
        chk("idle_lrdata", 32'(ldr_rdata), 32'(m_rdata[1]));
    endtask

    // Called at a falling edge while the DUT is idle; returns at a falling edge in idle.
    task automatic arb_cycle(input bit r0, input bit r1);
        int w, lat;
        logic we;
        logic [DATA_W-1:0] cap;
        check_idle();
        drive(r0, r1);
        if (!r0 && !r1) begin
            @(negedge clk);
            return;
        end
        if (r0 && r1) w = (m_last == 1) ? 0 : 1;
        else          w = r0 ? 0 : 1;
        m_last      = w;
        last_winner = w;
        we          = p_we[w];
        m_addr      = p_addr[w];
        m_dout      = p_wdata[w];
        lat         = we ? (WE_W + 3) : (RD_WAIT + 1);
        cap         = '0;
        @(posedge clk);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            ram_dq_in = use_fix ? fix_val : DATA_W'($urandom);
            if (!we && k == RD_WAIT) cap = ram_dq_in;
            if (k == lat && !we) m_rdata[w] = cap;
            chk("txn_oe",     32'(ram_oe),    32'(!we && k <= RD_WAIT));
            chk("txn_dqoe",   32'(ram_dq_oe), 32'(we && k <= WE_W + 2));
            chk("txn_we",     32'(ram_we),    32'(we && k >= 2 && k <= WE_W + 1));
            chk("txn_busy",   32'(busy),      1);
            chk("txn_addr",   32'(ram_addr),  32'(m_addr));
            chk("txn_dout",   32'(ram_dq_out), 32'(m_dout));
            chk("txn_cack",   32'(cpu_ack),   32'(k == lat && w == 0));
            chk("txn_lack",   32'(ldr_ack),   32'(k == lat && w == 1));
            chk("txn_crdata", 32'(cpu_rdata), 32'(m_rdata[0]));
            chk("txn_lrdata", 32'(ldr_rdata), 32'(m_rdata[1]));
            if (k == lat) begin
                if (w == 0) cpu_req = 1'b0;
                else        ldr_req = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Bus-safety invariants on every cycle
    always @(negedge clk) begin
        chk("inv_oe_vs_dqoe", 32'(ram_oe & ram_dq_oe), 0);
        chk("inv_we_needs_dqoe", 32'(ram_we & ~ram_dq_oe), 0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int j = 0; j < 2; j++) begin
            p_we[j] = 1'b0; p_addr[j] = '0; p_wdata[j] = '0; pend[j] = 1'b0;
        end
        last_winner = -1;
        model_reset();
        #1 rst_n = 1'b0;
        ram_dq_in = 8'hA5;
        repeat (2) @(negedge clk);

        // Reset state with no requests
        chk("rst_addr",   32'(ram_addr),   0);
        chk("rst_dout",   32'(ram_dq_out), 0);
        chk("rst_crdata", 32'(cpu_rdata),  0);
        chk("rst_lrdata", 32'(ldr_rdata),  0);
        chk("rst_acks",   32'({cpu_ack, ldr_ack}), 0);
        chk("rst_strobe", 32'({ram_oe, ram_we, ram_dq_oe}), 0);
        chk("rst_busy",   32'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // CPU read of the top address
        use_fix = 1'b1; fix_val = 8'h3C;
        p_we[0] = 1'b0; p_addr[0] = 5'h1F; p_wdata[0] = 8'h00;
        arb_cycle(1'b1, 1'b0);
        chk("cpu_rd_data", 32'(cpu_rdata), 'h3C);
        chk("cpu_rd_ldr_untouched", 32'(ldr_rdata), 0);
        chk("cpu_rd_winner", 32'(last_winner), 0);

        // Loader write
        p_we[1] = 1'b1; p_addr[1] = 5'h04; p_wdata[1] = 8'h7E;
        arb_cycle(1'b0, 1'b1);
        chk("ldr_wr_addr_hold", 32'(ram_addr),   'h04);
        chk("ldr_wr_dout_hold", 32'(ram_dq_out), 'h7E);
        use_fix = 1'b0;

        // Both ports reading continuously from reset: grants alternate, CPU first
        apply_reset();
        p_we[0] = 1'b0; p_addr[0] = 5'h02; p_wdata[0] = 8'h11;
        p_we[1] = 1'b0; p_addr[1] = 5'h13; p_wdata[1] = 8'h22;
        for (int i = 0; i < 4; i++) begin
            arb_cycle(1'b1, 1'b1);
            chk("rr_order", 32'(last_winner), 32'(i % 2));
        end

        // Reset asserted during the write-enable pulse
        p_we[1] = 1'b1; p_addr[1] = 5'h0A; p_wdata[1] = 8'h55;
        drive(1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("mid_su_dqoe", 32'(ram_dq_oe), 1);
        chk("mid_su_we",   32'(ram_we),    0);
        @(negedge clk);
        chk("mid_we_high", 32'(ram_we),    1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_we",   32'(ram_we),    0);
        chk("mid_rst_dqoe", 32'(ram_dq_oe), 0);
        chk("mid_rst_busy", 32'(busy),      0);
        ldr_req = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_no_ack", 32'({cpu_ack, ldr_ack}), 0);
            chk("mid_rst_idle",   32'(busy), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        p_we[0] = 1'b0; p_addr[0] = 5'h07; p_wdata[0] = 8'h99;
        arb_cycle(1'b1, 1'b0);
        chk("post_rst_winner", 32'(last_winner), 0);
        arb_cycle(1'b0, 1'b1);
        chk("post_rst_ldr_winner", 32'(last_winner), 1);

        // Random traffic on both ports
        for (int it = 0; it < 200; it++) begin
            bit any;
            for (int j = 0; j < 2; j++) begin
                if (!pend[j] && ($urandom_range(0, 1) == 1)) begin
                    pend[j]    = 1'b1;
                    p_we[j]    = 1'($urandom_range(0, 1));
                    p_addr[j]  = ADDR_W'($urandom);
                    p_wdata[j] = DATA_W'($urandom);
                end
            end
            any = pend[0] | pend[1];
            arb_cycle(pend[0], pend[1]);
            if (any) pend[last_winner] = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
